// File: rtl/signed_frame_acc_pkg.sv
// Shared definitions for the signed frame accumulator.
//
// Contents:
//   state_t   - FSM states. S_ACC collects samples. S_OUT presents a frame result.
//   sat_max() - largest value of a signed two's-complement number that is 'width' bits wide.
//   sat_min() - smallest value of a signed two's-complement number that is 'width' bits wide.
//
// Configuration macro used by the consumers of this package:
//   SIGNED_FRAME_ACC_SATURATE_EN

package signed_frame_acc_pkg;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/signed_frame_accumulator_add.sv
// signed_add_ovf_w: a combinational signed adder that is WIDTH bits wide.
// It reports two's-complement overflow.
//
// Ports:
//   a, b     in  WIDTH  signed operands
//   sum      out WIDTH  a + b, wrapped to WIDTH bits
//   overflow out 1      operands share a sign and the wrapped sum has the other sign
//
// The overflow rule is the same as in the upstream 4-bit add-with-overflow stage.
// For example, -2^(WIDTH-1) produced by two negatives is in range, so it is not flagged.

module signed_add_ovf_w #(
    parameter int WIDTH = 4
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    overflow
);

    assign sum      = a + b;
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/signed_frame_accumulator.sv
// signed_frame_accumulator: sums frames of COUNT signed samples.
// Each frame result carries a sticky overflow flag.
//
// Ports:
//   clk          in  1      rising-edge clock
//   rst          in  1      asynchronous reset, active high
//   in_valid     in  1      input sample present
//   in_ready     out 1      block accepts a sample this cycle (decoded from state only)
//   in_data      in  WIDTH  signed sample
//   out_valid    out 1      frame result present (registered)
//   out_ready    in  1      consumer takes the result
//   out_sum      out WIDTH  signed frame sum (registered)
//   out_overflow out 1      some step of the frame overflowed (registered)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// While valid is 1 and ready is 0, the producer holds its data stable.
// in_ready never depends combinationally on out_ready.
//
// Build option: when SIGNED_FRAME_ACC_SATURATE_EN is defined, an overflowing step clamps
// the accumulator to the signed range instead of wrapping. Overflow reporting does not change.

module signed_frame_accumulator
    import signed_frame_acc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_sum,
    output logic                    out_overflow
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    // FSM state is kept as a named signal so checkers can bind to it.
    state_t                  state;
    logic signed [WIDTH-1:0] acc;
    logic        [CNT_W-1:0] cnt;
    logic                    ovf_sticky;

    logic signed [WIDTH-1:0] add_sum;
    logic signed [WIDTH-1:0] next_acc;
    logic                    step_ovf;
    logic                    accept;

    signed_add_ovf_w #(
        .WIDTH(WIDTH)
    ) u_add (
        .a       (acc),
        .b       (in_data),
        .sum     (add_sum),
        .overflow(step_ovf)
    );

`ifdef SIGNED_FRAME_ACC_SATURATE_EN
    localparam logic signed [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic signed [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    // Overflow needs operands of equal sign, so the sign of acc selects the clamp rail.
    always_comb begin
        next_acc = add_sum;
        if (step_ovf) begin
            next_acc = acc[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign next_acc = add_sum;
`endif

    assign in_ready = (state == S_ACC);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_ACC;
            acc          <= '0;
            cnt          <= '0;
            ovf_sticky   <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (accept) begin
                        acc        <= next_acc;
                        ovf_sticky <= ovf_sticky | step_ovf;
                        if (cnt == CNT_LAST) begin
                            // The last sample of the frame goes straight into the output registers.
                            state        <= S_OUT;
                            cnt          <= '0;
                            out_valid    <= 1'b1;
                            out_sum      <= next_acc;
                            out_overflow <= ovf_sticky | step_ovf;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state      <= S_ACC;
                        out_valid  <= 1'b0;
                        acc        <= '0;
                        cnt        <= '0;
                        ovf_sticky <= 1'b0;
                    end
                end
                default: begin
                    state <= S_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_frame_accumulator.sv
// Directed testbench for signed_frame_accumulator (WIDTH=4, COUNT=4).
// A behavioural frame model, built from integer sums, predicts every result.
// A compare process checks the DUT against the model on each falling edge.
// Hand-computed literals pin both the model and the observed results.

module tb_signed_frame_accumulator;

    localparam int WIDTH = 4;
    localparam int COUNT = 4;
    localparam int MAXV  = (1 << (WIDTH - 1)) - 1;
    localparam int MINV  = -(1 << (WIDTH - 1));

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                    in_valid  = 1'b0;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data   = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [WIDTH-1:0] out_sum;
    logic                    out_overflow;

    signed_frame_accumulator #(
        .WIDTH(WIDTH),
        .COUNT(COUNT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_overflow(out_overflow)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_ovf_q[$];
    int               mdl_sum_hist[$];
    int               mdl_ovf_hist[$];
    int               obs_sum_q[$];
    int               obs_ovf_q[$];
    bit               exp_valid = 1'b0;
    int               run = 0;
    int               seen = 0;
    bit               sticky = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run = 0;
            seen = 0;
            sticky = 1'b0;
            exp_valid = 1'b0;
            exp_q.delete();
            exp_ovf_q.delete();
        end else begin
            bit take;
            int t;
            take = in_valid && !exp_valid;
            if (exp_valid && out_ready) begin
                void'(exp_q.pop_front());
                void'(exp_ovf_q.pop_front());
                exp_valid = 1'b0;
            end
            if (take) begin
                t = run + int'(in_data);
                if (t > MAXV) begin
                    sticky = 1'b1;
`ifdef SIGNED_FRAME_ACC_SATURATE_EN
                    t = MAXV;
`else
                    t = t - (1 << WIDTH);
`endif
                end else if (t < MINV) begin
                    sticky = 1'b1;
`ifdef SIGNED_FRAME_ACC_SATURATE_EN
                    t = MINV;
`else
                    t = t + (1 << WIDTH);
`endif
                end
                run = t;
                seen++;
                if (seen == COUNT) begin
                    exp_q.push_back(WIDTH'(run));
                    exp_ovf_q.push_back(sticky);
                    mdl_sum_hist.push_back(run);
                    mdl_ovf_hist.push_back(int'(sticky));
                    exp_valid = 1'b1;
                    run = 0;
                    seen = 0;
                    sticky = 1'b0;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_sum", int'(out_sum), 0);
            check("rst_out_overflow", int'(out_overflow), 0);
            check("rst_in_ready", int'(in_ready), 1);
        end else begin
            check("in_ready", int'(in_ready), int'(!exp_valid));
            check("out_valid", int'(out_valid), int'(exp_valid));
            if (exp_valid && exp_q.size() > 0) begin
                check("out_sum", int'(out_sum), int'($signed(exp_q[0])));
                check("out_overflow", int'(out_overflow), int'(exp_ovf_q[0]));
            end
            if (out_valid && out_ready) begin
                obs_sum_q.push_back(int'(out_sum));
                obs_ovf_q.push_back(int'(out_overflow));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int v);
        bit rdy;
        int cycles;
        in_valid = 1'b1;
        in_data  = WIDTH'(v);
        cycles   = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end while (!rdy && cycles < 50);
        if (!rdy) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string name, input int exp_sum, input int exp_ovf);
        int cycles;
        cycles = 0;
        while (obs_sum_q.size() == 0 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (obs_sum_q.size() == 0) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            check({name, "_dut_sum"}, obs_sum_q.pop_front(), exp_sum);
            check({name, "_dut_ovf"}, obs_ovf_q.pop_front(), exp_ovf);
        end
        if (mdl_sum_hist.size() == 0) begin
            check({name, "_model_missing"}, 0, 1);
        end else begin
            check({name, "_model_sum"}, mdl_sum_hist.pop_front(), exp_sum);
            check({name, "_model_ovf"}, mdl_ovf_hist.pop_front(), exp_ovf);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        idle(3);
        rst = 1'b0;
        idle(1);

        // 1: small mixed samples that cancel
        send(1); send(2); send(-1); send(-2);
        check_frame("t1", 0, 0);

        // 2: overflow mid-frame, sticky to the end
        send(4); send(7); send(-4); send(0);
`ifdef SIGNED_FRAME_ACC_SATURATE_EN
        check_frame("t2", 3, 1);
`else
        check_frame("t2", 7, 1);
`endif

        // 3: exactly the negative boundary, which is not an overflow
        send(-4); send(-4); send(0); send(0);
        check_frame("t3", -8, 0);

        // 4: backpressure while the next frame's first sample waits
        out_ready = 1'b0;
        send(3); send(-2); send(1); send(0);
        in_valid = 1'b1;
        in_data  = WIDTH'(1);
        idle(3);
        out_ready = 1'b1;
        send(1); send(1); send(1); send(1);
        check_frame("t4a", 2, 0);
        check_frame("t4b", 4, 0);

        // 5: reset mid-frame after an overflowing step
        send(7); send(7);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send(1); send(1); send(1); send(1);
        check_frame("t5", 4, 0);

        // 6: bubbles between samples
        send(2); idle(2); send(3); idle(2); send(-1); idle(2); send(1);
        check_frame("t6", 5, 0);

        idle(4);
        check("no_extra_results", obs_sum_q.size(), 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #50000;
        check("global_timeout", 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
